// File: rtl/key_debounce_bank.sv
// -----------------------------------------------------------------------------
// key_debounce_bank
//
// Debounces a bank of mechanical keys. It uses one shared scan counter for all
// keys. A key's debounced level changes only when two consecutive scan samples
// agree with each other and differ from the current level. The module also
// reports per-key press/release pulses, long-press pulses and a toggle level.
//
// Parameters
//   N_KEYS       number of key channels (1..16)
//   SCAN_CYCLES  clk cycles per scan period (>= 2)
//   LONG_SCANS   consecutive pressed scans before a long-press event (2..255)
//   ACTIVE_LOW   1: raw key reads 0 when pressed, 0: raw key reads 1 when pressed
//   TOGGLE_INIT  reset / clear value of o_toggle_out
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_key_in       raw asynchronous key levels
//   i_clr          synchronous clear of o_toggle_out to TOGGLE_INIT
//   o_key_state    debounced level per key, 1 = pressed
//   o_press        one-cycle pulse per key on debounced press
//   o_release      one-cycle pulse per key on debounced release
//   o_long_press   one-cycle pulse per key when held LONG_SCANS scans
//   o_toggle_out   per-key level that inverts on each press
//   o_any_event    OR of press, release and long-press pulses (same cycle)
// -----------------------------------------------------------------------------
module key_debounce_bank #(
    parameter int                 N_KEYS      = 2,
    parameter int                 SCAN_CYCLES = 1000000,
    parameter int                 LONG_SCANS  = 50,
    parameter int                 ACTIVE_LOW  = 1,
    parameter logic [N_KEYS-1:0]  TOGGLE_INIT = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] i_key_in,
    input  logic              i_clr,
    output logic [N_KEYS-1:0] o_key_state,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long_press,
    output logic [N_KEYS-1:0] o_toggle_out,
    output logic              o_any_event
);

    localparam int CNT_W  = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam int HOLD_W = $clog2(LONG_SCANS + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_SCANS);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_SCANS - 1);

    // The raw level of a key that is not pressed. The synchronizer resets to
    // this level so that no key looks pressed right after reset.
    localparam logic [N_KEYS-1:0] RELEASED_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // Two-flop synchronizer and polarity normalisation (1 = pressed)
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_key_norm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= RELEASED_RAW;
            r_sync2 <= RELEASED_RAW;
        end else begin
            r_sync1 <= i_key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_norm = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    // ------------------------------------------------------------------
    // Shared scan counter; w_tick strobes on the last count of each period
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_scan_cnt;
    logic             w_tick;

    assign w_tick = (r_scan_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
        end else if (w_tick) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sampling and debounce decision
    // r_sample holds the sample from the previous tick. The value being
    // captured on this tick is compared against it, so a change must be
    // seen on two consecutive ticks before it is accepted.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] r_sample;
    logic [N_KEYS-1:0] r_key_state;
    logic [N_KEYS-1:0] w_agree;
    logic [N_KEYS-1:0] w_rise;
    logic [N_KEYS-1:0] w_fall;

    assign w_agree = ~(w_key_norm ^ r_sample);
    assign w_rise  = w_tick ? (w_agree &  w_key_norm & ~r_key_state) : '0;
    assign w_fall  = w_tick ? (w_agree & ~w_key_norm &  r_key_state) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample    <= '0;
            r_key_state <= '0;
        end else begin
            if (w_tick) begin
                r_sample <= w_key_norm;
            end
            r_key_state <= (r_key_state | w_rise) & ~w_fall;
        end
    end

    // ------------------------------------------------------------------
    // Per-key hold counters and long-press detection.
    // A long press fires on the tick that moves the counter from
    // LONG_SCANS-1 to LONG_SCANS. The counter then saturates, so the event
    // cannot fire again until the key is released (counter cleared).
    // ------------------------------------------------------------------
    logic [HOLD_W-1:0] r_hold [N_KEYS];
    logic [N_KEYS-1:0] w_long_hit;

    always_comb begin
        w_long_hit = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            w_long_hit[k] = w_tick & r_key_state[k] & (r_hold[k] == HOLD_PRE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_KEYS; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (!r_key_state[k]) begin
                    r_hold[k] <= '0;
                end else if (w_tick && (r_hold[k] != HOLD_MAX)) begin
                    r_hold[k] <= r_hold[k] + HOLD_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered event pulses and toggle level.
    // i_clr has priority over the toggle only; the pulses are unaffected.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic [N_KEYS-1:0] r_long_press;
    logic [N_KEYS-1:0] r_toggle;
    logic              r_any_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press      <= '0;
            r_release    <= '0;
            r_long_press <= '0;
            r_toggle     <= TOGGLE_INIT;
            r_any_event  <= 1'b0;
        end else begin
            r_press      <= w_rise;
            r_release    <= w_fall;
            r_long_press <= w_long_hit;
            r_any_event  <= |{w_rise, w_fall, w_long_hit};
            if (i_clr) begin
                r_toggle <= TOGGLE_INIT;
            end else begin
                r_toggle <= r_toggle ^ w_rise;
            end
        end
    end

    assign o_key_state  = r_key_state;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long_press = r_long_press;
    assign o_toggle_out = r_toggle;
    assign o_any_event  = r_any_event;

endmodule
